axi_id_remap: RTL

- Read-path ID remapper that sits between an upstream AXI master port and the downstream interconnect.
- Each accepted AR request is given a compact transaction ID from `axi_id_pool` (this block drives the pool's alloc/dealloc ports) and the original ID is recorded in a lookup table.
- R beats are translated back to the original ID.
- The ID is returned to the pool on the last R beat.

---
 rtl/axi_id_remap.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_id_remap.sv
// axi_id_remap: read-path AXI ID remapper.
// Upstream AR requests get a compact ID from an external ID pool. The original
// ARID is kept in a lookup table, and R beats are translated back through that
// table. The pool ID is released on the last R beat of its burst.
//
// Ports:
//   clk, reset          single clock; synchronous active-low reset
//   s_ar*               upstream AR channel (valid/ready, id, addr)
//   m_ar*               downstream AR channel carrying the remapped id
//   m_r* / s_r*         R channel, combinational pass-through with id translation
//   alloc_*             pool allocation port (req out, valid/id in)
//   dealloc_*           pool release port, one-cycle pulse after a last beat
//   outstanding         number of pool ids currently held
//   err_unmapped        sticky flag: an R handshake arrived on an id that is not held
module axi_id_remap #(
   parameter int unsigned ID_WIDTH    = 4,
   parameter int unsigned ID_COUNT    = 1 << ID_WIDTH,
   parameter int unsigned IN_ID_WIDTH = 6,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   s_arvalid,
   output logic                   s_arready,
   input  logic [IN_ID_WIDTH-1:0] s_arid,
   input  logic [ADDR_WIDTH-1:0]  s_araddr,
   output logic                   m_arvalid,
   input  logic                   m_arready,
   output logic [ID_WIDTH-1:0]    m_arid,
   output logic [ADDR_WIDTH-1:0]  m_araddr,
   input  logic                   m_rvalid,
   output logic                   m_rready,
   input  logic [ID_WIDTH-1:0]    m_rid,
   input  logic [DATA_WIDTH-1:0]  m_rdata,
   input  logic                   m_rlast,
   output logic                   s_rvalid,
   input  logic                   s_rready,
   output logic [IN_ID_WIDTH-1:0] s_rid,
   output logic [DATA_WIDTH-1:0]  s_rdata,
   output logic                   s_rlast,
   output logic                   alloc_req,
   input  logic                   alloc_valid,
   input  logic [ID_WIDTH-1:0]    alloc_id,
   output logic                   dealloc_req,
   output logic [ID_WIDTH-1:0]    dealloc_id,
   output logic [ID_WIDTH:0]      outstanding,
   output logic                   err_unmapped
);

   localparam int unsigned CNT_WIDTH = ID_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALLOC = 2'd1,
      ST_ISSUE = 2'd2
   } state_e;

   typedef struct packed {
      logic [IN_ID_WIDTH-1:0] id;
      logic [ADDR_WIDTH-1:0]  addr;
   } ar_req_t;

   state_e                 state_q;
   state_e                 state_d;

   logic                   s_arready_q;
   logic                   s_arready_d;
   logic                   alloc_req_q;
   logic                   alloc_req_d;
   logic                   m_arvalid_q;
   logic                   m_arvalid_d;
   ar_req_t                ar_q;
   logic [ID_WIDTH-1:0]    m_arid_q;

   logic [IN_ID_WIDTH-1:0] id_tbl [ID_COUNT];
   logic [ID_COUNT-1:0]    vld_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic                   dealloc_req_q;
   logic [ID_WIDTH-1:0]    dealloc_id_q;
   logic                   err_q;

   logic                   ar_accept;
   logic                   grant;
   logic                   r_hs;
   logic                   r_hit;
   logic                   rel;
   logic                   unmapped;

   // Handshake qualifiers. s_arready is registered, so acceptance uses the
   // registered value; this keeps IDLE closed in the first cycle after reset.
   assign ar_accept = (state_q == ST_IDLE) && s_arvalid && s_arready_q;
   assign grant     = (state_q == ST_ALLOC) && alloc_req_q && alloc_valid;
   assign r_hs      = m_rvalid && s_rready;
   assign r_hit     = vld_q[m_rid];
   assign rel       = r_hs && m_rlast && r_hit;
   assign unmapped  = r_hs && !r_hit;

   // AR FSM state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // AR FSM next-state logic; ALLOC waits indefinitely for a pool grant
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (ar_accept) state_d = ST_ALLOC;
         ST_ALLOC: if (grant)     state_d = ST_ISSUE;
         ST_ISSUE: if (m_arready) state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   // AR FSM outputs, decoded from the next state so the registered copies
   // line up with the state they belong to
   always_comb begin
      s_arready_d = 1'b0;
      alloc_req_d = 1'b0;
      m_arvalid_d = 1'b0;
      case (state_d)
         ST_IDLE:  s_arready_d = 1'b1;
         ST_ALLOC: alloc_req_d = 1'b1;
         ST_ISSUE: m_arvalid_d = 1'b1;
         default:  ;
      endcase
   end

   // Registered AR control outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         s_arready_q <= 1'b0;
         alloc_req_q <= 1'b0;
         m_arvalid_q <= 1'b0;
      end else begin
         s_arready_q <= s_arready_d;
         alloc_req_q <= alloc_req_d;
         m_arvalid_q <= m_arvalid_d;
      end
   end

   // Latched AR payload; held from acceptance until the downstream handshake
   always_ff @(posedge clk) begin
      if (!reset) begin
         ar_q <= '0;
      end else if (ar_accept) begin
         ar_q <= '{id: s_arid, addr: s_araddr};
      end
   end

   // Remapped id captured on the pool grant
   always_ff @(posedge clk) begin
      if (!reset) begin
         m_arid_q <= '0;
      end else if (grant) begin
         m_arid_q <= alloc_id;
      end
   end

   // Lookup table; contents are meaningless unless the matching vld bit is set
   always_ff @(posedge clk) begin
      if (grant) begin
         id_tbl[alloc_id] <= ar_q.id;
      end
   end

   // Valid bits. Grant and release never hit the same entry: the pool cannot
   // hand out an id again before it has seen the dealloc for it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_q <= '0;
      end else begin
         if (rel) begin
            vld_q[m_rid] <= 1'b0;
         end
         if (grant) begin
            vld_q[alloc_id] <= 1'b1;
         end
      end
   end

   // Held-id counter; grant and release in the same cycle cancel out
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         case ({grant, rel})
            2'b10:   cnt_q <= cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_q <= cnt_q - CNT_WIDTH'(1);
            default: ;
         endcase
      end
   end

   // Release pulse to the pool, one cycle after the last-beat handshake
   always_ff @(posedge clk) begin
      if (!reset) begin
         dealloc_req_q <= 1'b0;
         dealloc_id_q  <= '0;
      end else begin
         dealloc_req_q <= rel;
         if (rel) begin
            dealloc_id_q <= m_rid;
         end
      end
   end

   // Sticky unmapped-response flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (unmapped) begin
         err_q <= 1'b1;
      end
   end

   assign s_arready    = s_arready_q;
   assign alloc_req    = alloc_req_q;
   assign m_arvalid    = m_arvalid_q;
   assign m_arid       = m_arid_q;
   assign m_araddr     = ar_q.addr;
   assign dealloc_req  = dealloc_req_q;
   assign dealloc_id   = dealloc_id_q;
   assign outstanding  = cnt_q;
   assign err_unmapped = err_q;

   // R path: combinational pass-through with id translation
   assign s_rvalid = m_rvalid;
   assign m_rready = s_rready;
   assign s_rdata  = m_rdata;
   assign s_rlast  = m_rlast;
   assign s_rid    = id_tbl[m_rid];

endmodule
